// File: rtl/bus_pkg.sv
// Shared constants and packet-field helpers for the bus device endpoint.
package bus_pkg;
  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_DEF = 8'h0F;
  // Widest packet the helper accepts; callers zero-extend into this.
  localparam int PKT_MAX = 256;

  // Destination ID occupies the top ID_W bits of an sz-bit packet.
  function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX-1:0] pkt,
                                              input int unsigned sz);
    return pkt[sz-1 -: ID_W];
  endfunction
endpackage

// File: rtl/ep_fifo.sv
// Show-ahead FIFO with extra-MSB pointers; a push while full is taken when a pop
// frees the head slot in the same cycle.
module ep_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         din,
  output logic [width-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);
  localparam int AW = $clog2(depth);

  logic [AW:0]      wptr, rptr;
  logic [width-1:0] mem [depth];
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = wptr - rptr;
  // Empty FIFO presents zeros rather than stale storage.
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  // Pointer update; natural binary rollover handles wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/bus_dev_endpoint.sv
// Bus device endpoint: host-side TX/RX FIFOs, destination filtering on
// delivered packets, drop counter and sticky error flags.
module bus_dev_endpoint
  import bus_pkg::*;
#(
  parameter int              pckg_sz   = 16,
  parameter int              depth     = 8,
  parameter logic [ID_W-1:0] id        = 8'd0,
  parameter logic [ID_W-1:0] broadcast = BCAST_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [pckg_sz-1:0] wr_data,
  output logic               tx_full,
  input  logic               rd_en,
  output logic [pckg_sz-1:0] rd_data,
  output logic               rx_empty,
  output logic               pndng,
  input  logic               pop,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic [7:0]         drop_cnt,
  output logic [1:0]         err
);
  localparam int CW = $clog2(depth) + 1;

  logic               tx_empty, rx_full;
  logic [CW-1:0]      tx_cnt, rx_cnt;
  logic [PKT_MAX-1:0] push_ext;
  logic [ID_W-1:0]    dest;
  logic               hit, accept, ovf, drop;
  logic               unused_cnt;

  assign push_ext = PKT_MAX'(D_push);
  assign dest     = dest_of(push_ext, pckg_sz);
  assign hit      = (dest == id) || (dest == broadcast);
  assign accept   = push & hit;
  // An accepted packet only overflows when the host is not draining this cycle.
  assign ovf      = accept & rx_full & ~rd_en;
  assign drop     = (push & ~hit) | ovf;
  assign pndng    = ~tx_empty;
  assign unused_cnt = ^{tx_cnt, rx_cnt};

  ep_fifo #(.width(pckg_sz), .depth(depth)) u_tx (
    .clk(clk), .rst_n(reset), .push(wr_en), .pop(pop), .din(wr_data),
    .dout(D_pop), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );

  ep_fifo #(.width(pckg_sz), .depth(depth)) u_rx (
    .clk(clk), .rst_n(reset), .push(accept), .pop(rd_en), .din(D_push),
    .dout(rd_data), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );

  // Saturating drop counter and sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
      err      <= '0;
    end else begin
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      err <= err | {ovf, pop & tx_empty};
    end
  end
endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Directed bench for bus_dev_endpoint (id=2, depth=8, 16-bit packets).
module tb_bus_dev_endpoint;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, rd_en, pop, push;
  logic [15:0] wr_data, D_push;
  logic        tx_full, rx_empty, pndng;
  logic [15:0] rd_data, D_pop;
  logic [7:0]  drop_cnt;
  logic [1:0]  err;

  int passed = 0;
  int total  = 0;

  bus_dev_endpoint #(.pckg_sz(16), .depth(8), .id(8'd2), .broadcast(8'h0F)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .pndng(pndng),
    .pop(pop), .D_pop(D_pop), .push(push), .D_push(D_push),
    .drop_cnt(drop_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [15:0] wr_data;
    logic        pop;
    logic        push;
    logic [15:0] d_push;
    logic        rd_en;
    logic        e_pndng;
    logic [15:0] e_dpop;
    logic        e_full;
    logic        e_rxe;
    logic [15:0] e_rd;
    logic [7:0]  e_drop;
    logic [1:0]  e_err;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic idle();
    wr_en = 0; wr_data = '0; pop = 0; push = 0; D_push = '0; rd_en = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #2;
    chk("rst_pndng", pndng, 0);
    chk("rst_full", tx_full, 0);
    chk("rst_rxe", rx_empty, 1);
    chk("rst_dpop", D_pop, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_err", err, 0);
    #10 reset = 1'b1;

    //          wr wdata    pop psh dpush    rd  pnd dpop     full rxe rd       drop err
    tv[0]  = '{1, 16'h0A11, 0, 0, 16'h0000, 0,  1, 16'h0A11, 0, 1, 16'h0000, 0, 0};
    tv[1]  = '{1, 16'h0B22, 0, 0, 16'h0000, 0,  1, 16'h0A11, 0, 1, 16'h0000, 0, 0};
    tv[2]  = '{0, 16'h0000, 1, 0, 16'h0000, 0,  1, 16'h0B22, 0, 1, 16'h0000, 0, 0};
    tv[3]  = '{0, 16'h0000, 1, 0, 16'h0000, 0,  0, 16'h0000, 0, 1, 16'h0000, 0, 0};
    tv[4]  = '{0, 16'h0000, 0, 1, 16'h0255, 0,  0, 16'h0000, 0, 0, 16'h0255, 0, 0};
    tv[5]  = '{0, 16'h0000, 0, 1, 16'h0F33, 0,  0, 16'h0000, 0, 0, 16'h0255, 0, 0};
    tv[6]  = '{0, 16'h0000, 0, 1, 16'h0377, 0,  0, 16'h0000, 0, 0, 16'h0255, 1, 0};
    tv[7]  = '{0, 16'h0000, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 0, 16'h0F33, 1, 0};
    tv[8]  = '{0, 16'h0000, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 1, 0};
    tv[9]  = '{0, 16'h0000, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 1, 0};
    tv[10] = '{0, 16'h0000, 0, 1, 16'h0000, 0,  0, 16'h0000, 0, 1, 16'h0000, 2, 0};
    tv[11] = '{1, 16'h1234, 0, 1, 16'h0F00, 0,  1, 16'h1234, 0, 0, 16'h0F00, 2, 0};
    tv[12] = '{0, 16'h0000, 1, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 2, 0};

    for (int i = 0; i < 13; i++) begin
      wr_en = tv[i].wr_en; wr_data = tv[i].wr_data; pop = tv[i].pop;
      push = tv[i].push; D_push = tv[i].d_push; rd_en = tv[i].rd_en;
      tick();
      chk($sformatf("v%0d_pndng", i), pndng, tv[i].e_pndng);
      chk($sformatf("v%0d_dpop", i), D_pop, tv[i].e_dpop);
      chk($sformatf("v%0d_full", i), tx_full, tv[i].e_full);
      chk($sformatf("v%0d_rxe", i), rx_empty, tv[i].e_rxe);
      chk($sformatf("v%0d_rd", i), rd_data, tv[i].e_rd);
      chk($sformatf("v%0d_drop", i), drop_cnt, tv[i].e_drop);
      chk($sformatf("v%0d_err", i), err, tv[i].e_err);
    end
    idle();

    // TX fill, write-while-full with pop, ignored write without pop.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_data = 16'h1000 + 16'(i);
      tick();
    end
    chk("txfill_full", tx_full, 1);
    chk("txfill_head", D_pop, 16'h1000);
    wr_en = 1; wr_data = 16'h1008; pop = 1;
    tick();
    chk("tx9_full", tx_full, 1);
    chk("tx9_head", D_pop, 16'h1001);
    wr_en = 1; wr_data = 16'h1009; pop = 0;
    tick();
    chk("tx10_full", tx_full, 1);
    chk("tx10_err", err, 0);
    idle();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("txdrain%0d", i), D_pop, 16'h1001 + 16'(i));
      pop = 1;
      tick();
      pop = 0;
    end
    chk("txdrain_pndng", pndng, 0);
    chk("txdrain_full", tx_full, 0);

    // RX fill, overflow drop, then push-while-full with read.
    for (int i = 0; i < 8; i++) begin
      push = 1; D_push = 16'h0200 + 16'(i);
      tick();
    end
    push = 1; D_push = 16'h0299;
    tick();
    chk("rxovf_drop", drop_cnt, 3);
    chk("rxovf_err", err, 2'b10);
    chk("rxovf_head", rd_data, 16'h0200);
    push = 1; D_push = 16'h02AA; rd_en = 1;
    tick();
    chk("rxfullrd_drop", drop_cnt, 3);
    chk("rxfullrd_head", rd_data, 16'h0201);
    idle();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rxdrain%0d", i), rd_data, (i == 7) ? 16'h02AA : 16'h0201 + 16'(i));
      rd_en = 1;
      tick();
      rd_en = 0;
    end
    chk("rxdrain_empty", rx_empty, 1);

    // Pop on empty TX.
    pop = 1;
    tick();
    pop = 0;
    chk("popempty_err", err, 2'b11);
    chk("popempty_dpop", D_pop, 0);
    chk("popempty_pndng", pndng, 0);
    tick();
    chk("err_sticky", err, 2'b11);

    // Drop counter saturation.
    for (int i = 0; i < 252; i++) begin
      push = 1; D_push = 16'h0011;
      tick();
    end
    chk("drop_255", drop_cnt, 8'hFF);
    tick();
    idle();
    chk("drop_hold", drop_cnt, 8'hFF);

    // Asynchronous reset with 3 TX entries queued.
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_data = 16'h5000 + 16'(i);
      tick();
    end
    idle();
    chk("prerst_pndng", pndng, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_pndng", pndng, 0);
    chk("arst_dpop", D_pop, 0);
    chk("arst_err", err, 0);
    chk("arst_drop", drop_cnt, 0);
    chk("arst_rxe", rx_empty, 1);
    #3 reset = 1'b1;
    tick();
    chk("postrst_pndng", pndng, 0);
    wr_en = 1; wr_data = 16'h0C0C;
    tick();
    idle();
    chk("postrst_wr_pndng", pndng, 1);
    chk("postrst_wr_dpop", D_pop, 16'h0C0C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bus_dev_endpoint.md
BUS_DEV_ENDPOINT -- requirements
Module: bus_dev_endpoint

Interface
REQ-001 Parameter pckg_sz, default 16: packet width in bits; bits [pckg_sz-1:pckg_sz-8] are the destination ID, and the remaining bits are payload.
REQ-002 Parameter depth, default 8: entries per FIFO; shall be a power of two, 2 to 64.
REQ-003 Parameter id, default 0: this device's 8-bit ID.
REQ-004 Parameter broadcast, default 8'h0F: broadcast destination ID.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  1  host write into TX FIFO.
REQ-008 wr_data  in  pckg_sz  host packet to transmit.
REQ-009 tx_full  out  1  TX FIFO full.
REQ-010 rd_en  in  1  host read from RX FIFO.
REQ-011 rd_data  out  pckg_sz  RX FIFO head (show-ahead).
REQ-012 rx_empty  out  1  RX FIFO empty.
REQ-013 pndng  out  1  TX FIFO holds at least one packet, visible to the bus arbiter.
REQ-014 pop  in  1  arbiter consumes the TX head.
REQ-015 D_pop  out  pckg_sz  TX FIFO head (show-ahead).
REQ-016 push  in  1  arbiter delivers a packet.
REQ-017 D_push  in  pckg_sz  delivered packet.
REQ-018 drop_cnt  out  8  count of delivered packets dropped (misaddressed or RX full); saturates at 255.
REQ-019 err  out  2  sticky flags: bit0 = pop while TX empty; bit1 = RX overflow.

Function
REQ-020 pndng shall equal NOT tx_empty, combinationally from registered state, with no added latency.
REQ-021 D_pop shall present the TX head whenever pndng=1, and all zeros when the TX FIFO is empty.
REQ-022 pop=1 with pndng=1 shall advance the TX read pointer at the clock edge; the next head appears on D_pop the following cycle.
REQ-023 pop=1 with pndng=0 shall leave all pointers unchanged and set err[0].
REQ-024 wr_en=1 with tx_full=0 shall store wr_data at the clock edge.
REQ-025 wr_en=1 with tx_full=1 and pop=1 in the same cycle shall be accepted: occupancy stays at depth.
REQ-026 wr_en=1 with tx_full=1 and pop=0 shall be ignored, with no flag raised; the host must observe tx_full.
REQ-027 A write into an empty TX FIFO shall raise pndng the cycle after the write edge (1-cycle latency).
REQ-028 push=1 shall sample D_push at the edge; the packet is accepted only if its destination field equals id or broadcast.
REQ-029 A misaddressed push shall be dropped and shall increment drop_cnt.
REQ-030 An accepted push while the RX FIFO is full and rd_en=0 shall be dropped, increment drop_cnt, and set err[1].
REQ-031 An accepted push while the RX FIFO is full and rd_en=1 shall be stored, with occupancy unchanged.
REQ-032 rd_en=1 while rx_empty=1 shall be ignored.
REQ-033 Pointers shall be log2(depth)+1 bits wide; full = MSBs differ and LSBs equal; empty = pointers equal; wrap-around is natural binary rollover.
REQ-034 drop_cnt shall hold at 255 once reached.
REQ-035 err bits shall clear only on reset.

Reset
REQ-036 With reset=0, asynchronously: all pointers 0, pndng=0, tx_full=0, rx_empty=1, D_pop=0, drop_cnt=0, err=0.
REQ-037 Assertion of reset mid-transfer shall discard all FIFO contents; the first post-reset edge shall behave as an empty endpoint.
REQ-038 FIFO storage arrays need not be reset.

Structure
REQ-039 Package bus_pkg shall hold ID_W=8, the default broadcast constant, and a function returning the destination field of a packet.
REQ-040 One sub-module, ep_fifo (parameters width and depth; show-ahead; push/pop/full/empty/count), shall be instantiated twice, once for TX and once for RX.
REQ-041 Address filtering, counters and error flags shall live in the top module.

Verification
REQ-042 Host writes 16'h0A11, 16'h0B22; pop on two consecutive cycles -> pndng rises 1 cycle after the first write, D_pop shows 0A11 then 0B22, and pndng falls after the second pop.
REQ-043 id=2: push D_push=16'h0255, then 16'h0F33, then 16'h0377 -> RX holds 0255 and 0F33, drop_cnt=1.
REQ-044 Fill TX with 8 writes -> tx_full=1; a 9th write with pop=1 is accepted with occupancy 8; a 10th write without pop is ignored.
REQ-045 Fill RX with 8 entries, then push a 9th -> drop_cnt increments, err[1]=1, and RX contents are unchanged.
REQ-046 pop with TX empty -> err[0]=1 and D_pop=0; drive reset=0 mid-stream with 3 TX entries -> pndng=0 immediately (asynchronously), and err and drop_cnt are cleared.
